mem_axi_master_bridge: RTL and testbench
========================================

Name: mem_axi_master_bridge

Overview:
- Converts single-word HWPE-style memory requests (req/gnt/r_valid) into single-beat AXI4 master transactions.
- It is the initiator-side counterpart of axi_slave_mem_wrap. A memory-protocol master (HWPE engine, BRAM_wrap-style client) uses it to reach any AXI4 slave, including axi_slave_mem_wrap itself in loopback benches.
- One outstanding transaction at a time.

Parameters:
- AXI_ID_WIDTH, 2, width of AXI ID fields.
- AXI_ADDR_WIDTH, 10, byte address width on both sides.
- AXI_DATA_WIDTH, 32, data width on both sides.
- AXI_USER_WIDTH, 10, width of AXI user fields (driven 0).
- AXI_ID, 0, constant ID placed on aw_id/ar_id.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_req_i  in  1  memory request.
- data_add_i  in  AXI_ADDR_WIDTH  byte address.
- data_wen_i  in  1  request type: 0 = store, 1 = load.
- data_wdata_i  in  AXI_DATA_WIDTH  store data.
- data_be_i  in  AXI_DATA_WIDTH/8  byte enables.
- data_gnt_o  out  1  request accepted this cycle.
- data_r_valid_o  out  1  one-cycle response pulse for load and store.
- data_r_rdata_o  out  AXI_DATA_WIDTH  load data, valid with data_r_valid_o.
- data_err_o  out  1  response was SLVERR/DECERR, valid with data_r_valid_o.
- AXI_master_aw{id,addr,valid} out, AXI_master_awready in  write address channel.
- AXI_master_aw{len,size,burst,lock,cache,prot,qos,region,user}  out  tied: 0, log2(AXI_DATA_WIDTH/8), 2'b01 INCR, all others 0.
- AXI_master_w{data,strb,valid} out, w_last out (constant 1), w_user out (0), AXI_master_wready in  write data channel.
- AXI_master_b{id,resp,user,valid} in, AXI_master_bready out  write response channel.
- AXI_master_ar{id,addr,valid} out, ar{len,size,burst,lock,cache,prot,qos,region,user} out tied as for AW, AXI_master_arready in  read address channel.
- AXI_master_r{id,data,resp,last,user,valid} in, AXI_master_rready out  read data channel.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All valid/ready outputs, data_gnt_o, data_r_valid_o and data_err_o are 0. data_r_rdata_o and the latched address/data/be are 0.
- A reset mid-transaction drops AXI valids immediately. No response is produced.
- FSM states:
  - IDLE, WRITE, WR_RESP, READ, RD_DATA.
- IDLE:
  - data_gnt_o = data_req_i (combinational, only in IDLE).
  - On grant: latch add/wen/wdata/be. Go to WRITE if wen=0, else READ.
- WRITE:
  - awvalid and wvalid are asserted together from the first WRITE cycle.
  - Each valid drops individually after its own handshake; the AW and W handshakes may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP.
  - awaddr = latched add. wdata/wstrb = latched wdata/be.
- WR_RESP:
  - bready=1. On bvalid: go to IDLE.
  - Register data_r_valid_o=1 and data_err_o=bresp[1]. Both are visible the next cycle.
- READ:
  - arvalid=1, araddr = latched add. On arready: go to RD_DATA.
- RD_DATA:
  - rready=1. On rvalid: capture rdata into data_r_rdata_o and set data_err_o=rresp[1].
  - Pulse data_r_valid_o next cycle, go to IDLE.
  - rlast is ignored.
- Response IDs are not checked.
- data_r_valid_o is high exactly one cycle. data_r_rdata_o holds its value until the next load response.
- A new request may be granted in the same cycle data_r_valid_o is high.
- Minimum latency with zero-wait slave:
  - Store: grant T, AW+W T+1, B T+2, r_valid T+3.
  - Load: grant T, AR T+1, R T+2, r_valid T+3.
- AXI stability rule: once awvalid/wvalid/arvalid is asserted, address, data and strb are held constant until the handshake completes.
- data_req_i while not in IDLE is simply not granted. The requester holds it.

Test Plan:
- Store, zero-wait slave: req, add=0x010, wdata=0xDEADBEEF, be=0xF -> gnt at T; AW/W handshake at T+1 with awaddr=0x010, wstrb=0xF, wlast=1, awlen=0, awsize=2; r_valid pulse at T+3 with err=0.
- Load: after the store, load add=0x010 -> araddr=0x010; r_valid one cycle with rdata=0xDEADBEEF; err=0.
- Independent channel ordering, three cases: awready 3 cycles before wready, wready first, and both same cycle -> exactly one AW and one W handshake each; addr/data stable while waiting; single r_valid.
- Back-to-back requests: req held high for 4 stores then 4 loads to 0x000..0x00C (data i) -> second request granted in the r_valid cycle of the first; loads return 0,1,2,3 in order.
- Error response: slave returns bresp=2'b10, then rresp=2'b11 -> data_err_o=1 with each r_valid pulse.
- Reset mid-op: rst_n low while in RD_DATA with rvalid withheld -> all valids 0 within the reset cycle, no r_valid; after release, a new load completes normally.
- Loopback bench: bridge driving axi_slave_mem_wrap + BRAM_wrap_four_byte, write 16 words 0..15 then read 20 -> words 0..15 match.

Source files
------------

// File: rtl/mem_axi_master_bridge.sv
// mem_axi_master_bridge
// Turns single-word memory requests (req/gnt/r_valid) into single-beat AXI4 master
// transactions. Only one transaction is in flight at a time.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   data_req_i .. data_be_i    memory-side request (wen: 0 = store, 1 = load)
//   data_gnt_o                 request accepted this cycle (IDLE only)
//   data_r_valid_o             one-cycle response pulse for loads and stores
//   data_r_rdata_o             load data, held until the next load response
//   data_err_o                 response was SLVERR/DECERR
//   AXI_master_aw*/w*/b*       AXI4 write address, data and response channels
//   AXI_master_ar*/r*          AXI4 read address and data channels
module mem_axi_master_bridge #(
   parameter int unsigned AXI_ID_WIDTH   = 2,
   parameter int unsigned AXI_ADDR_WIDTH = 10,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_USER_WIDTH = 10,
   parameter int unsigned AXI_ID         = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   // Memory-protocol slave side
   input  logic                        data_req_i,
   input  logic [AXI_ADDR_WIDTH-1:0]   data_add_i,
   input  logic                        data_wen_i,
   input  logic [AXI_DATA_WIDTH-1:0]   data_wdata_i,
   input  logic [AXI_DATA_WIDTH/8-1:0] data_be_i,
   output logic                        data_gnt_o,
   output logic                        data_r_valid_o,
   output logic [AXI_DATA_WIDTH-1:0]   data_r_rdata_o,
   output logic                        data_err_o,
   // AXI write address channel
   output logic [AXI_ID_WIDTH-1:0]     AXI_master_awid,
   output logic [AXI_ADDR_WIDTH-1:0]   AXI_master_awaddr,
   output logic [7:0]                  AXI_master_awlen,
   output logic [2:0]                  AXI_master_awsize,
   output logic [1:0]                  AXI_master_awburst,
   output logic                        AXI_master_awlock,
   output logic [3:0]                  AXI_master_awcache,
   output logic [2:0]                  AXI_master_awprot,
   output logic [3:0]                  AXI_master_awregion,
   output logic [3:0]                  AXI_master_awqos,
   output logic [AXI_USER_WIDTH-1:0]   AXI_master_awuser,
   output logic                        AXI_master_awvalid,
   input  logic                        AXI_master_awready,
   // AXI write data channel
   output logic [AXI_DATA_WIDTH-1:0]   AXI_master_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] AXI_master_wstrb,
   output logic                        AXI_master_wlast,
   output logic [AXI_USER_WIDTH-1:0]   AXI_master_wuser,
   output logic                        AXI_master_wvalid,
   input  logic                        AXI_master_wready,
   // AXI write response channel
   input  logic [AXI_ID_WIDTH-1:0]     AXI_master_bid,
   input  logic [1:0]                  AXI_master_bresp,
   input  logic [AXI_USER_WIDTH-1:0]   AXI_master_buser,
   input  logic                        AXI_master_bvalid,
   output logic                        AXI_master_bready,
   // AXI read address channel
   output logic [AXI_ID_WIDTH-1:0]     AXI_master_arid,
   output logic [AXI_ADDR_WIDTH-1:0]   AXI_master_araddr,
   output logic [7:0]                  AXI_master_arlen,
   output logic [2:0]                  AXI_master_arsize,
   output logic [1:0]                  AXI_master_arburst,
   output logic                        AXI_master_arlock,
   output logic [3:0]                  AXI_master_arcache,
   output logic [2:0]                  AXI_master_arprot,
   output logic [3:0]                  AXI_master_arregion,
   output logic [3:0]                  AXI_master_arqos,
   output logic [AXI_USER_WIDTH-1:0]   AXI_master_aruser,
   output logic                        AXI_master_arvalid,
   input  logic                        AXI_master_arready,
   // AXI read data channel
   input  logic [AXI_ID_WIDTH-1:0]     AXI_master_rid,
   input  logic [AXI_DATA_WIDTH-1:0]   AXI_master_rdata,
   input  logic [1:0]                  AXI_master_rresp,
   input  logic                        AXI_master_rlast,
   input  logic [AXI_USER_WIDTH-1:0]   AXI_master_ruser,
   input  logic                        AXI_master_rvalid,
   output logic                        AXI_master_rready
);

   localparam int unsigned StrbWidth = AXI_DATA_WIDTH / 8;
   localparam logic [2:0]  AxSize    = 3'($clog2(StrbWidth));

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StWrResp,
      StRead,
      StRdData
   } state_e;

   state_e                      state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0]   add_q, add_d;
   logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [StrbWidth-1:0]        be_q, be_d;
   logic                        aw_done_q, aw_done_d;
   logic                        w_done_q, w_done_d;
   logic                        r_valid_q, r_valid_d;
   logic                        err_q, err_d;
   logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;

   logic aw_valid, w_valid, ar_valid, b_ready, r_ready, gnt;

   always_comb begin
      state_d   = state_q;
      add_d     = add_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      r_valid_d = 1'b0;
      err_d     = err_q;
      rdata_d   = rdata_q;
      gnt       = 1'b0;
      aw_valid  = 1'b0;
      w_valid   = 1'b0;
      ar_valid  = 1'b0;
      b_ready   = 1'b0;
      r_ready   = 1'b0;

      unique case (state_q)
         StIdle: begin
            gnt = data_req_i;
            if (data_req_i) begin
               add_d     = data_add_i;
               wdata_d   = data_wdata_i;
               be_d      = data_be_i;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = data_wen_i ? StRead : StWrite;
            end
         end
         StWrite: begin
            // AW and W retire independently; each valid drops after its own handshake.
            aw_valid = ~aw_done_q;
            w_valid  = ~w_done_q;
            if (aw_valid && AXI_master_awready) aw_done_d = 1'b1;
            if (w_valid && AXI_master_wready)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d)          state_d   = StWrResp;
         end
         StWrResp: begin
            b_ready = 1'b1;
            if (AXI_master_bvalid) begin
               r_valid_d = 1'b1;
               err_d     = AXI_master_bresp[1];
               state_d   = StIdle;
            end
         end
         StRead: begin
            ar_valid = 1'b1;
            if (AXI_master_arready) state_d = StRdData;
         end
         StRdData: begin
            r_ready = 1'b1;
            if (AXI_master_rvalid) begin
               rdata_d   = AXI_master_rdata;
               err_d     = AXI_master_rresp[1];
               r_valid_d = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         add_q     <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         r_valid_q <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         add_q     <= add_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         r_valid_q <= r_valid_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign data_gnt_o     = gnt;
   assign data_r_valid_o = r_valid_q;
   assign data_r_rdata_o = rdata_q;
   assign data_err_o     = err_q;

   assign AXI_master_awid     = AXI_ID_WIDTH'(AXI_ID);
   assign AXI_master_awaddr   = add_q;
   assign AXI_master_awlen    = 8'd0;
   assign AXI_master_awsize   = AxSize;
   assign AXI_master_awburst  = 2'b01;
   assign AXI_master_awlock   = 1'b0;
   assign AXI_master_awcache  = 4'd0;
   assign AXI_master_awprot   = 3'd0;
   assign AXI_master_awregion = 4'd0;
   assign AXI_master_awqos    = 4'd0;
   assign AXI_master_awuser   = '0;
   assign AXI_master_awvalid  = aw_valid;

   assign AXI_master_wdata    = wdata_q;
   assign AXI_master_wstrb    = be_q;
   assign AXI_master_wlast    = 1'b1;
   assign AXI_master_wuser    = '0;
   assign AXI_master_wvalid   = w_valid;

   assign AXI_master_bready   = b_ready;

   assign AXI_master_arid     = AXI_ID_WIDTH'(AXI_ID);
   assign AXI_master_araddr   = add_q;
   assign AXI_master_arlen    = 8'd0;
   assign AXI_master_arsize   = AxSize;
   assign AXI_master_arburst  = 2'b01;
   assign AXI_master_arlock   = 1'b0;
   assign AXI_master_arcache  = 4'd0;
   assign AXI_master_arprot   = 3'd0;
   assign AXI_master_arregion = 4'd0;
   assign AXI_master_arqos    = 4'd0;
   assign AXI_master_aruser   = '0;
   assign AXI_master_arvalid  = ar_valid;

   assign AXI_master_rready   = r_ready;

   // Response IDs, user bits, rlast and the low resp bits carry no meaning here.
   logic unused_inputs;
   assign unused_inputs = ^{AXI_master_bid, AXI_master_buser, AXI_master_bresp[0],
                            AXI_master_rid, AXI_master_ruser, AXI_master_rresp[0],
                            AXI_master_rlast};

endmodule

// File: tb/tb_mem_axi_master_bridge.sv
module tb_mem_axi_master_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, wen, gnt, r_valid, err;
   logic [9:0]  add;
   logic [31:0] wdata, rdata;
   logic [3:0]  be;

   logic [1:0]  awid, arid, bid, rid;
   logic [9:0]  awaddr, araddr;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize, awprot, arprot;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awlock, arlock, awvalid, awready, wvalid, wready, wlast;
   logic [3:0]  awcache, arcache, awregion, arregion, awqos, arqos, wstrb;
   logic [9:0]  awuser, aruser, wuser, buser, ruser;
   logic [31:0] axi_wdata, axi_rdata;
   logic        bvalid, bready, arvalid, arready, rvalid, rready, rlast;

   always #5 clk = ~clk;

   mem_axi_master_bridge dut (
      .clk(clk), .rst_n(rst_n),
      .data_req_i(req), .data_add_i(add), .data_wen_i(wen), .data_wdata_i(wdata),
      .data_be_i(be), .data_gnt_o(gnt), .data_r_valid_o(r_valid), .data_r_rdata_o(rdata),
      .data_err_o(err),
      .AXI_master_awid(awid), .AXI_master_awaddr(awaddr), .AXI_master_awlen(awlen),
      .AXI_master_awsize(awsize), .AXI_master_awburst(awburst), .AXI_master_awlock(awlock),
      .AXI_master_awcache(awcache), .AXI_master_awprot(awprot),
      .AXI_master_awregion(awregion), .AXI_master_awqos(awqos), .AXI_master_awuser(awuser),
      .AXI_master_awvalid(awvalid), .AXI_master_awready(awready),
      .AXI_master_wdata(axi_wdata), .AXI_master_wstrb(wstrb), .AXI_master_wlast(wlast),
      .AXI_master_wuser(wuser), .AXI_master_wvalid(wvalid), .AXI_master_wready(wready),
      .AXI_master_bid(bid), .AXI_master_bresp(bresp), .AXI_master_buser(buser),
      .AXI_master_bvalid(bvalid), .AXI_master_bready(bready),
      .AXI_master_arid(arid), .AXI_master_araddr(araddr), .AXI_master_arlen(arlen),
      .AXI_master_arsize(arsize), .AXI_master_arburst(arburst), .AXI_master_arlock(arlock),
      .AXI_master_arcache(arcache), .AXI_master_arprot(arprot),
      .AXI_master_arregion(arregion), .AXI_master_arqos(arqos), .AXI_master_aruser(aruser),
      .AXI_master_arvalid(arvalid), .AXI_master_arready(arready),
      .AXI_master_rid(rid), .AXI_master_rdata(axi_rdata), .AXI_master_rresp(rresp),
      .AXI_master_rlast(rlast), .AXI_master_ruser(ruser), .AXI_master_rvalid(rvalid),
      .AXI_master_rready(rready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- slave model configuration (written by stimulus only) --------------
   int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   bit         r_hold = 1'b0;

   // ---------------- slave model state (written by the slave only) ---------------------
   logic [31:0] mem [0:255];
   int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
   int          aw_hs = 0, w_hs = 0, ar_hs = 0, stab_err = 0;
   bit          aw_got, w_got, b_pend, r_pend;
   logic [9:0]  cap_awaddr, cap_araddr, ref_awaddr;
   logic [31:0] cap_wdata, ref_wdata;
   logic [3:0]  cap_wstrb, ref_wstrb;

   // Runs on the falling edge: readies/valids set here are what the DUT samples at the next
   // rising edge, so a handshake is known here one half-cycle before it happens.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      {awready, wready, bvalid, arready, rvalid} = '0;
      {bid, rid, buser, ruser, bresp, rresp, axi_rdata, rlast} = '0;
      {aw_got, w_got, b_pend, r_pend} = '0;
      {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            {awready, wready, bvalid, arready, rvalid} = '0;
            {aw_got, w_got, b_pend, r_pend} = '0;
            {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
         end else begin
            // B
            bvalid = 1'b0;
            if (b_pend) begin
               if (b_wait >= b_dly) begin
                  bvalid = 1'b1;
                  bresp  = bresp_cfg;
                  if (bready) b_pend = 1'b0;
               end else b_wait++;
            end
            // R
            rvalid = 1'b0;
            if (r_pend && !r_hold) begin
               if (r_wait >= r_dly) begin
                  rvalid    = 1'b1;
                  rlast     = 1'b1;
                  axi_rdata = mem[cap_araddr[9:2]];
                  rresp     = rresp_cfg;
                  if (rready) r_pend = 1'b0;
               end else r_wait++;
            end
            // AW
            if (awvalid) begin
               if (aw_wait == 0) ref_awaddr = awaddr;
               else if (awaddr !== ref_awaddr) stab_err++;
               awready = (aw_wait >= aw_dly);
               if (awready) begin aw_hs++; cap_awaddr = awaddr; aw_got = 1'b1; end
               aw_wait++;
            end else begin
               awready = 1'b0;
               aw_wait = 0;
            end
            // W
            if (wvalid) begin
               if (w_wait == 0) begin ref_wdata = axi_wdata; ref_wstrb = wstrb; end
               else if (axi_wdata !== ref_wdata || wstrb !== ref_wstrb) stab_err++;
               wready = (w_wait >= w_dly);
               if (wready) begin w_hs++; cap_wdata = axi_wdata; cap_wstrb = wstrb; w_got = 1'b1; end
               w_wait++;
            end else begin
               wready = 1'b0;
               w_wait = 0;
            end
            if (aw_got && w_got) begin
               for (int b = 0; b < 4; b++)
                  if (cap_wstrb[b]) mem[cap_awaddr[9:2]][8*b +: 8] = cap_wdata[8*b +: 8];
               aw_got = 1'b0;
               w_got  = 1'b0;
               b_pend = 1'b1;
               b_wait = 0;
            end
            // AR
            if (arvalid) begin
               arready = (ar_wait >= ar_dly);
               if (arready) begin ar_hs++; cap_araddr = araddr; r_pend = 1'b1; r_wait = 0; end
               ar_wait++;
            end else begin
               arready = 1'b0;
               ar_wait = 0;
            end
         end
      end
   end

   // ---------------- vector table ------------------------------------------------------
   typedef struct {
      bit          load;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
      logic [1:0]  bresp, rresp;
      logic [31:0] exp_rdata;
      bit          exp_err;
      int          exp_lat;   // cycles from grant to r_valid
   } vec_t;

   function automatic vec_t mk(bit load, logic [9:0] addr, logic [31:0] wd, logic [3:0] be_v,
                               int awd, int wd_d, int bd, int ard, int rd,
                               logic [1:0] br, logic [1:0] rr,
                               logic [31:0] er, bit ee, int lat);
      vec_t v;
      v.load = load; v.addr = addr; v.wdata = wd; v.be = be_v;
      v.aw_dly = awd; v.w_dly = wd_d; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd;
      v.bresp = br; v.rresp = rr; v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
      return v;
   endfunction

   task automatic run_vec(input string tag, input vec_t v);
      int lat;
      int aw0, w0, ar0, st0;
      bit got;
      aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly;
      ar_dly = v.ar_dly; r_dly = v.r_dly; bresp_cfg = v.bresp; rresp_cfg = v.rresp;
      aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; st0 = stab_err;
      @(negedge clk);
      req = 1'b1; add = v.addr; wen = v.load; wdata = v.wdata; be = v.be;
      #1;
      lat = 0;
      while (!gnt && lat < 50) begin @(negedge clk); #1; lat++; end
      chk({tag, "_gnt"}, 32'(gnt), 32'd1);
      @(negedge clk);
      req = 1'b0;
      #1;
      lat = 1;
      got = 1'b0;
      while (!got && lat < 60) begin
         if (r_valid) got = 1'b1;
         else begin @(negedge clk); #1; lat++; end
      end
      chk({tag, "_rvalid"}, 32'(got), 32'd1);
      chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
      chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
      if (v.load) begin
         chk({tag, "_rdata"}, rdata, v.exp_rdata);
         chk({tag, "_ar_hs"}, 32'(ar_hs - ar0), 32'd1);
         chk({tag, "_araddr"}, 32'(cap_araddr), 32'(v.addr));
      end else begin
         chk({tag, "_aw_hs"}, 32'(aw_hs - aw0), 32'd1);
         chk({tag, "_w_hs"}, 32'(w_hs - w0), 32'd1);
         chk({tag, "_awaddr"}, 32'(cap_awaddr), 32'(v.addr));
         chk({tag, "_wdata"}, cap_wdata, v.wdata);
         chk({tag, "_wstrb"}, 32'(cap_wstrb), 32'(v.be));
         chk({tag, "_stable"}, 32'(stab_err - st0), 32'd0);
      end
      @(negedge clk);
      #1;
      chk({tag, "_rvalid_1cyc"}, 32'(r_valid), 32'd0);
   endtask

   vec_t vecs[11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cnt;
      vecs[0]  = mk(0, 10'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0, 3);
      vecs[1]  = mk(1, 10'h010, 32'h0, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hDEADBEEF, 0, 3);
      vecs[2]  = mk(0, 10'h020, 32'h11223344, 4'hF, 0, 3, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0, 6);
      vecs[3]  = mk(0, 10'h024, 32'h55667788, 4'hF, 3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0, 6);
      vecs[4]  = mk(0, 10'h028, 32'hA5A5A5A5, 4'hF, 2, 2, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0, 5);
      vecs[5]  = mk(1, 10'h020, 32'h0, 4'hF, 0, 0, 0, 1, 2, 2'b00, 2'b00, 32'h11223344, 0, 6);
      vecs[6]  = mk(0, 10'h020, 32'hCAFEBEEF, 4'h3, 0, 0, 1, 0, 0, 2'b00, 2'b00, 32'h0, 0, 4);
      vecs[7]  = mk(1, 10'h020, 32'h0, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h1122BEEF, 0, 3);
      vecs[8]  = mk(0, 10'h030, 32'h0, 4'hF, 0, 0, 0, 0, 0, 2'b10, 2'b00, 32'h0, 1, 3);
      vecs[9]  = mk(1, 10'h024, 32'h0, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b11, 32'h55667788, 1, 3);
      vecs[10] = mk(1, 10'h028, 32'h0, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hA5A5A5A5, 0, 3);

      rst_n = 1'b0;
      req = 1'b0; wen = 1'b0; add = '0; wdata = '0; be = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rvalid", 32'(r_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
      chk("rst_awaddr", 32'(awaddr), 32'd0);
      chk("tie_awlen_arlen", 32'({awlen, arlen}), 32'd0);
      chk("tie_awsize", 32'(awsize), 32'd2);
      chk("tie_arsize", 32'(arsize), 32'd2);
      chk("tie_bursts", 32'({awburst, arburst}), 32'b0101);
      chk("tie_wlast", 32'(wlast), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Back-to-back: req held high, 4 stores then 4 loads; each grant lands on r_valid.
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
      bresp_cfg = 2'b00; rresp_cfg = 2'b00;
      @(negedge clk);
      req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         wen = (k >= 4); add = 10'(4 * (k % 4)); wdata = 32'(k % 4); be = 4'hF;
         #1;
         n = 0;
         while (!gnt && n < 50) begin @(negedge clk); #1; n++; end
         chk($sformatf("b2b_gnt%0d", k), 32'(gnt), 32'd1);
         if (k > 0) chk($sformatf("b2b_gnt_on_rvalid%0d", k), 32'(r_valid), 32'd1);
         if (k >= 5) chk($sformatf("b2b_rdata%0d", k - 5), rdata, 32'(k - 5));
         @(negedge clk);
      end
      req = 1'b0;
      #1;
      n = 0;
      while (!r_valid && n < 50) begin @(negedge clk); #1; n++; end
      chk("b2b_last_rvalid", 32'(r_valid), 32'd1);
      chk("b2b_rdata3", rdata, 32'd3);

      // Reset while waiting in RD_DATA with rvalid withheld.
      r_hold = 1'b1;
      @(negedge clk);
      req = 1'b1; wen = 1'b1; add = 10'h024;
      #1;
      n = 0;
      while (!gnt && n < 50) begin @(negedge clk); #1; n++; end
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_rready", 32'(rready), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
      chk("mid_rst_rvalid", 32'(r_valid), 32'd0);
      chk("mid_rst_rdata", rdata, 32'd0);
      repeat (2) @(negedge clk);
      r_hold = 1'b0;
      rst_n  = 1'b1;
      cnt = 0;
      repeat (5) begin @(negedge clk); #1; if (r_valid) cnt++; end
      chk("mid_rst_no_resp", 32'(cnt), 32'd0);
      run_vec("post_rst", mk(1, 10'h024, 32'h0, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00,
                             32'h55667788, 0, 3));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
